// File: rtl/rotseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rotseq_pkg
//  Description : Shared types and default constants for the rotate-load
//                sequencer. Optional macro: ROTSEQ_FIFO_EN (2-entry buffer).
//  Revision    : 1.0 - initial release
// ============================================================================
package rotseq_pkg;

  localparam int c_DEF_DW         = 4;
  localparam int c_DEF_ROT_CYCLES = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2
  } state_t;

  // Width of the rotate-cycle counter; leaves headroom so it never wraps.
  function automatic int cnt_width(input int rot_cycles);
    return $clog2(rot_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rotseq_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rotseq_buf
//  Description : Push/pop word buffer with full/empty flags. ROTSEQ_FIFO_EN
//                defined: 2-deep FIFO; undefined: single holding register.
//                Flush empties the buffer and wins over a same-cycle push.
//  Revision    : 1.0 - initial release
// ============================================================================
module rotseq_buf
  import rotseq_pkg::*;
#(
  parameter int DW = c_DEF_DW
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

`ifdef ROTSEQ_FIFO_EN
  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;

  // Pointers wrap modulo 2 by toggling; occupancy tracks push/pop balance.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: it is only read while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
`else
  logic          r_valid;
  logic [DW-1:0] r_hold;

  // Single slot: a push fills it, a pop empties it; they never coincide
  // because a push needs the slot empty and a pop needs it full.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_valid <= 1'b0;
      r_hold  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_hold  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_hold;
  assign o_full  = r_valid;
  assign o_empty = ~r_valid;
`endif

endmodule
`default_nettype wire

// File: rtl/rotate_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_load_sequencer
//  Description : Buffers upstream words and, for each, issues a one-cycle
//                load strobe followed by ROT_CYCLES rotate-enable cycles to
//                the downstream rotate register. Optional macro:
//                ROTSEQ_FIFO_EN selects a 2-entry buffer instead of one slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module rotate_load_sequencer
  import rotseq_pkg::*;
#(
  parameter int DW         = c_DEF_DW,
  parameter int ROT_CYCLES = c_DEF_ROT_CYCLES
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          load,
  output logic          en,
  output logic [DW-1:0] data,
  output logic          busy,
  output logic          done
);

  localparam int              c_CW   = cnt_width(ROT_CYCLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(ROT_CYCLES - 1);

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_load;
  logic            r_en;
  logic            r_busy;
  logic            r_done;
  logic [DW-1:0]   r_data;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_last;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [DW-1:0]   w_head;

  assign w_last    = (r_cnt == c_LAST);
  assign w_cnt_nxt = r_cnt + c_CW'(1);
  assign w_push    = in_valid & ~w_full;
  // The head word leaves the buffer on the edge that enters LOAD.
  assign w_pop     = ~flush & ~w_empty &
                     ((r_state == ST_IDLE) | ((r_state == ST_ROTATE) & w_last));
  assign in_ready  = ~w_full;

  rotseq_buf #(
    .DW (DW)
  ) u_buf (
    .clk       (clk),
    .async_rst (async_rst),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (in_data),
    .o_data    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Sequencer FSM with all downstream-facing outputs registered.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_data  <= w_head;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_ROTATE;
          r_cnt   <= '0;
          r_load  <= 1'b0;
          r_en    <= 1'b1;
          r_done  <= (c_LAST == '0);
        end
        ST_ROTATE: begin
          if (w_last) begin
            r_en   <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            if (w_pop) begin
              // Back-to-back: next word loads with no idle gap.
              r_state <= ST_LOAD;
              r_data  <= w_head;
              r_load  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= (w_cnt_nxt == c_LAST);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_load  <= 1'b0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign load = r_load;
  assign en   = r_en;
  assign data = r_data;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rotate_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotate_load_sequencer
//  Description : Self-checking bench for rotate_load_sequencer (DW=4,
//                ROT_CYCLES=7): vector table, corner-case sequences and a
//                randomized run against a cycle-slot reference model.
//                Honours ROTSEQ_FIFO_EN for the expected buffer capacity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_load_sequencer;

  localparam int DW  = 4;
  localparam int ROT = 7;
  localparam int NV  = ROT + 4;
`ifdef ROTSEQ_FIFO_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          async_rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          load;
  logic          en;
  logic [DW-1:0] data;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       fl;
    logic       ld;
    logic       e;
    logic [3:0] dat;
    logic       bz;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t       tbl [NV];
  logic [3:0] b2b_w [3];
  logic       b2b_rdy [3];
  int         load_t [3];
  logic [3:0] load_d [3];
  int         sent, nload, nen;
  logic       idle_gap, accw;

  // reference model state: slot = cycles since current word's load (-1 none)
  logic [3:0] mq [$];
  int         m_slot;
  logic [3:0] m_data;
  logic       m_acc;

  always #5 clk = ~clk;

  rotate_load_sequencer #(.DW(DW), .ROT_CYCLES(ROT)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .load      (load),
    .en        (en),
    .data      (data),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ld, input logic e,
                         input logic [3:0] d, input logic bz, input logic dn);
    chk({tag, ".load"}, 32'(load), 32'(ld));
    chk({tag, ".en"},   32'(en),   32'(e));
    chk({tag, ".data"}, 32'(data), 32'(d));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word accepted on the previous edge while idle with an otherwise empty buffer.
  task automatic expect_word(input string tag, input logic [3:0] w);
    tick;
    chk_out({tag, ".load"}, 1'b1, 1'b0, w, 1'b1, 1'b0);
    for (int i = 1; i <= ROT; i++) begin
      tick;
      chk_out($sformatf("%s.rot%0d", tag, i), 1'b0, 1'b1, w, 1'b1, (i == ROT));
    end
    tick;
    chk_out({tag, ".idle"}, 1'b0, 1'b0, w, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick;
      n++;
    end
    chk({tag, ".idle_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---------------- vector table: single word 4'h9 ----------------
    for (int k = 0; k < NV; k++)
      tbl[k] = '{v:1'b0, d:4'h0, fl:1'b0, ld:1'b0, e:1'b0, dat:4'h9,
                 bz:1'b0, dn:1'b0, rdy:1'b1};
    tbl[0].v   = 1'b1;
    tbl[0].d   = 4'h9;
    tbl[0].dat = 4'h0;
    tbl[0].rdy = (CAP == 1) ? 1'b0 : 1'b1;
    tbl[1].ld  = 1'b1;
    tbl[1].bz  = 1'b1;
    for (int k = 2; k <= ROT + 1; k++) begin
      tbl[k].e  = 1'b1;
      tbl[k].bz = 1'b1;
    end
    tbl[ROT + 1].dn = 1'b1;

    // ---------------- reset pulse between edges ----------------
    #1 async_rst = 1'b1;
    #2 async_rst = 1'b0;
    #1;
    chk_out("reset", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < NV; k++) begin
      in_valid = tbl[k].v;
      in_data  = tbl[k].d;
      flush    = tbl[k].fl;
      tick;
      chk_out($sformatf("vec%0d", k), tbl[k].ld, tbl[k].e, tbl[k].dat, tbl[k].bz, tbl[k].dn);
      chk($sformatf("vec%0d.in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
    end
    in_valid = 1'b0;

    // ---------------- back-to-back words 9, 6, 3 ----------------
    b2b_w[0] = 4'h9; b2b_w[1] = 4'h6; b2b_w[2] = 4'h3;
    b2b_rdy[0] = (CAP == 1) ? 1'b0 : 1'b1;
    b2b_rdy[1] = (CAP == 1) ? 1'b0 : 1'b1;
    b2b_rdy[2] = 1'b0;
    sent = 0; nload = 0; idle_gap = 1'b0;
    for (int cyc = 0; cyc < 60 && nload < 3; cyc++) begin
      in_valid = (sent < 3);
      in_data  = (sent < 3) ? b2b_w[sent] : 4'h0;
      accw     = in_valid && in_ready;
      tick;
      if (accw) begin
        chk($sformatf("b2b.ready_after_accept%0d", sent), 32'(in_ready), 32'(b2b_rdy[sent]));
        sent++;
      end
      if (load) begin
        if (nload == 0) chk("b2b.ready_in_first_load", 32'(in_ready), 32'd1);
        load_t[nload] = cyc;
        load_d[nload] = data;
        nload++;
      end else if (nload > 0 && !busy) begin
        idle_gap = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("b2b.load_count", 32'(nload), 32'd3);
    if (nload == 3) begin
      chk("b2b.data0", 32'(load_d[0]), 32'h9);
      chk("b2b.data1", 32'(load_d[1]), 32'h6);
      chk("b2b.data2", 32'(load_d[2]), 32'h3);
      chk("b2b.gap01", 32'(load_t[1] - load_t[0]), 32'(ROT + 1));
      chk("b2b.gap12", 32'(load_t[2] - load_t[1]), 32'(ROT + 1));
    end
    chk("b2b.no_idle_gap", 32'(idle_gap), 32'd0);
    wait_idle("b2b");

    // ---------------- flush in 3rd ROTATE cycle with 4'h6 queued ----------------
    in_valid = 1'b1; in_data = 4'h9;
    tick;
    in_data = 4'h6; sent = 0; nen = 0;
    for (int cyc = 0; cyc < 20 && nen < 3; cyc++) begin
      accw = in_valid && in_ready;
      tick;
      if (accw) begin sent = 1; in_valid = 1'b0; end
      if (en) nen++;
    end
    in_valid = 1'b0;
    chk("flush.word6_queued", 32'(sent), 32'd1);
    chk("flush.reached_rot3", 32'(nen), 32'd3);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk_out("flush.next", 1'b0, 1'b0, 4'h9, 1'b0, 1'b0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("flush.no_load", 32'(load | done | busy), 32'd0);
    end
    chk("flush.data_kept", 32'(data), 32'h9);

    // ---------------- async reset mid-ROTATE ----------------
    in_valid = 1'b1; in_data = 4'h9;
    tick;
    in_data = 4'h5; sent = 0; nen = 0;
    for (int cyc = 0; cyc < 20 && nen < 2; cyc++) begin
      accw = in_valid && in_ready;
      tick;
      if (accw) begin sent = 1; in_valid = 1'b0; end
      if (en) nen++;
    end
    in_valid = 1'b0;
    chk("arst.word5_queued", 32'(sent), 32'd1);
    #2 async_rst = 1'b1;
    #1;
    chk_out("arst.immediate", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("arst.in_ready", 32'(in_ready), 32'd1);
    #2 async_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("arst.queued_discarded", 32'(load | busy), 32'd0);
    end
    in_valid = 1'b1; in_data = 4'hA;
    tick;
    in_valid = 1'b0;
    expect_word("arst.new", 4'hA);

    // ---------------- flush with buffer full and in_valid held ----------------
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && in_ready; cyc++) begin
      in_data = 4'($urandom_range(15));
      tick;
    end
    chk("fullflush.reached_full", 32'(in_ready), 32'd0);
    in_data = 4'hC;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fullflush.in_ready", 32'(in_ready), 32'd1);
    chk("fullflush.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("fullflush.no_capture", 32'(load), 32'd0);
    end

    // ---------------- randomized run against reference model ----------------
    #2 async_rst = 1'b1;
    #2 async_rst = 1'b0;
    mq.delete();
    m_slot = -1;
    m_data = 4'h0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      in_valid = ($urandom_range(99) < 55);
      flush    = ($urandom_range(99) < 4);
      in_data  = 4'($urandom);
      m_acc = in_valid && (mq.size() < CAP);
      if (flush) begin
        mq.delete();
        m_slot = -1;
      end else begin
        if (m_slot == -1 || m_slot == ROT) begin
          if (mq.size() > 0) begin
            m_data = mq.pop_front();
            m_slot = 0;
          end else begin
            m_slot = -1;
          end
        end else begin
          m_slot++;
        end
        if (m_acc) mq.push_back(in_data);
      end
      tick;
      chk($sformatf("rand%0d.{load,en,done,busy,in_ready,data}", cyc),
          32'({load, en, done, busy, in_ready, data}),
          32'({(m_slot == 0), (m_slot >= 1), (m_slot == ROT), (m_slot >= 0),
               (mq.size() < CAP), m_data}));
      chk($sformatf("rand%0d.load_en_exclusive", cyc), 32'(load & en), 32'd0);
    end
    in_valid = 1'b0;
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
